stream_flush_ctrl: RTL
======================

# stream_flush_ctrl

Flush initiator for a flushable spill stage on a valid/ready stream. It sits directly upstream of the stage: it forwards the stream transparently, counts beats held inside the stage, and on request gates the upstream, drives the stage's flush input, and reports how many beats were discarded. The stage requires that valid and flush are never high together; this block enforces that by construction.

## Interface
- T, logic: payload type.
- FlushCycles, 1: cycles flush_o stays high per flush; legal range 1..15.
- CntWidth, 2: width of the in-flight counter; must hold the stage capacity (2 beats for a spill stage).
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_i  in  T  upstream payload.
- valid_o  out  1  valid to the stage.
- ready_i  in  1  ready from the stage.
- data_o  out  T  payload to the stage.
- flush_o  out  1  flush to the stage.
- exit_hs_i  in  1  stage output handshake (stage valid_o & consumer ready), one pulse per beat leaving.
- flush_req_i  in  1  flush request, sampled in IDLE only.
- flush_ack_o  out  1  one-cycle pulse: flush complete, dropped_o valid.
- dropped_o  out  CntWidth  beats discarded by the last flush; held until the next ack.
- inflight_o  out  CntWidth  current beats held in the stage.
- err_o  out  1  one-cycle pulse on counter overflow or underflow.

## Operation
- States: IDLE, FLUSH, ACK.
- IDLE: valid_o = valid_i, ready_o = ready_i, data_o = data_i, all combinational. flush_o = 0.
- IDLE -> FLUSH at the clock edge where flush_req_i = 1. The handshake in that same cycle completes normally and is counted.
- FLUSH: valid_o = 0, ready_o = 0, flush_o = 1. A down-counter loaded with FlushCycles-1 on entry counts to 0, then the state moves to ACK.
- On the FLUSH entry edge, dropped_o captures the in-flight count as updated by that edge: the entry handshake adds 1 and exit_hs_i subtracts 1.
- During FLUSH, exit_hs_i is ignored. The in-flight counter is cleared to 0 on the FLUSH -> ACK edge.
- ACK: flush_ack_o = 1 for exactly one cycle, valid_o = 0, ready_o = 0, flush_o = 0. ACK -> IDLE unconditionally.
- flush_req_i is ignored in FLUSH and ACK. The requester drops it in the ack cycle. If it is still high in the next IDLE cycle, a new flush starts.
- In-flight counter, IDLE only:
  - +1 on valid_o & ready_i.
  - -1 on exit_hs_i.
  - Both at once: unchanged.
- Increment at all-ones: counter saturates and err_o pulses.
- Decrement at 0: counter stays 0 and err_o pulses.
- Arithmetic is unsigned CntWidth; there is no wrap-around.

## Timing
- Forward path has zero latency in IDLE (combinational).
- Flush occupies FlushCycles + 1 cycles, from the first cycle flush_o is high to the ack cycle inclusive. The upstream stalls for exactly these cycles.
- flush_o and valid_o are never high in the same cycle.
- Reset values: state IDLE, flush_o 0, flush_ack_o 0, dropped_o 0, inflight_o 0, err_o 0. valid_o and ready_o follow valid_i and ready_i, since the block is in IDLE.
- Reset asserted mid-flush: immediate return to IDLE, all counters 0, flush_o low asynchronously. No ack is issued.

## Structure
- Package stream_flush_pkg holds the state enum (IDLE, FLUSH, ACK) and the FlushCycles counter width constant (4 bits).
- One sub-module, stream_inflight_cnt: a saturating up/down counter.
  - Inputs: inc, dec, clr, en.
  - Outputs: count, err.
  - Instantiated once; the FSM drives en = (state == IDLE).

## Test plan
- Pass-through: 8 beats 0x11..0x18 with ready_i = 1 and exit_hs_i echoing the stage two cycles later -> data_o matches data_i in the same cycle, inflight_o never exceeds 2, err_o never pulses.
- Flush with two held beats: fill the stage with 0xA, 0xB (ready_i = 0 downstream), then flush_req_i pulse, FlushCycles = 1 -> flush_o high for 1 cycle, ack in the next cycle, dropped_o = 2, inflight_o = 0, no cycle with valid_o & flush_o.
- Handshake on the request edge: valid_i = ready_i = 1, flush_req_i = 1 in the same cycle, inflight 1 before -> beat accepted, dropped_o = 2.
- Longer flush: FlushCycles = 3 -> flush_o high for 3 consecutive cycles, ready_o low for 4 cycles, ack on the 4th cycle.
- Error cases:
  - exit_hs_i with inflight 0 -> err_o pulses once, inflight_o stays 0.
  - CntWidth = 2 with 4 unmatched increments -> the 4th increment pulses err_o, inflight_o stays 3.
- Reset during FLUSH: rst_ni low in the 2nd flush cycle -> flush_o low immediately, no flush_ack_o, normal pass-through after release.

Source files
------------

// File: rtl/stream_flush_pkg.sv
// Shared types and constants for the stream flush controller.
package stream_flush_pkg;

  localparam int unsigned FlushCntWidth = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } flush_state_e;

endpackage

// File: rtl/stream_inflight_cnt.sv
// Saturating up/down beat counter with a one-cycle error pulse on overflow or underflow.
module stream_inflight_cnt #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [Width-1:0] o_count,
  output logic             o_err
);

  localparam logic [Width-1:0] CntMax = '1;

  logic [Width-1:0] r_count;
  logic             r_err;

  // Clear wins over counting; simultaneous inc and dec leave the count alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (i_en && i_inc && !i_dec) begin
      if (r_count == CntMax) begin
        r_err <= 1'b1;
      end else begin
        r_count <= r_count + Width'(1);
        r_err   <= 1'b0;
      end
    end else if (i_en && i_dec && !i_inc) begin
      if (r_count == '0) begin
        r_err <= 1'b1;
      end else begin
        r_count <= r_count - Width'(1);
        r_err   <= 1'b0;
      end
    end else begin
      r_err <= 1'b0;
    end
  end

  assign o_count = r_count;
  assign o_err   = r_err;

endmodule

// File: rtl/stream_flush_ctrl.sv
// Flush initiator for a spill stage: transparent forwarding, in-flight tracking,
// and a gated flush sequence that reports how many beats were discarded.
module stream_flush_ctrl
  import stream_flush_pkg::*;
#(
  parameter type         T           = logic,
  parameter int unsigned FlushCycles = 1,
  parameter int unsigned CntWidth    = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  T                    data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output T                    data_o,
  output logic                flush_o,
  input  logic                exit_hs_i,
  input  logic                flush_req_i,
  output logic                flush_ack_o,
  output logic [CntWidth-1:0] dropped_o,
  output logic [CntWidth-1:0] inflight_o,
  output logic                err_o
);

  flush_state_e             r_state;
  logic [FlushCntWidth-1:0] r_flush_cnt;
  logic                     r_flush;
  logic                     r_ack;
  logic [CntWidth-1:0]      r_dropped;

  logic                     w_idle;
  logic                     w_hs;
  logic                     w_clr;
  logic [CntWidth-1:0]      w_count;
  logic [CntWidth-1:0]      w_cnt_next;

  // Upstream is gated entirely outside IDLE, so valid_o and flush_o never overlap.
  assign w_idle  = (r_state == IDLE);
  assign valid_o = w_idle & valid_i;
  assign ready_o = w_idle & ready_i;
  assign data_o  = data_i;
  assign w_hs    = valid_o & ready_i;
  assign w_clr   = (r_state == FLUSH) && (r_flush_cnt == '0);

  stream_inflight_cnt #(
    .Width (CntWidth)
  ) u_inflight_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_inc   (w_hs),
    .i_dec   (exit_hs_i),
    .i_clr   (w_clr),
    .i_en    (w_idle),
    .o_count (w_count),
    .o_err   (err_o)
  );

  // Count as it will be after this edge, so the entry handshake is included in dropped_o.
  always_comb begin
    w_cnt_next = w_count;
    if (w_hs && !exit_hs_i && (w_count != '1)) begin
      w_cnt_next = w_count + CntWidth'(1);
    end else if (!w_hs && exit_hs_i && (w_count != '0)) begin
      w_cnt_next = w_count - CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
      r_flush     <= 1'b0;
      r_ack       <= 1'b0;
      r_dropped   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 1'b0;
          if (flush_req_i) begin
            r_state     <= FLUSH;
            r_flush     <= 1'b1;
            r_flush_cnt <= FlushCntWidth'(FlushCycles - 1);
            r_dropped   <= w_cnt_next;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= ACK;
            r_flush <= 1'b0;
            r_ack   <= 1'b1;
          end else begin
            r_flush_cnt <= r_flush_cnt - FlushCntWidth'(1);
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_flush <= 1'b0;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign flush_o     = r_flush;
  assign flush_ack_o = r_ack;
  assign dropped_o   = r_dropped;
  assign inflight_o  = w_count;

endmodule
